// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage behind the register file.
//   Runs the ALUK-selected operation on SR1 and SR2, where SR2 has already
//   been muxed with imm5. The result is registered for the DATAP bus mux.
//   The block also holds the NZP condition codes.
//   Single-cycle ops finish at their accept edge. When the optional
//   multiplier is built, MUL takes WIDTH clocks and holds Busy high meanwhile.
// Build option: define ALU_MUL_EN to build the iterative multiplier (ALUK=100).
//   When it is not defined, ALUK=100 decodes as PASSA and Busy is tied to 0.
// Ports:
//   Clk, Reset        clock (rising edge); synchronous active-high reset
//   Start, ALUK       op request (taken when Busy==0) and op select
//   SR1, SR2          operands A and B
//   LD_CC, BUS        load NZP from the CPU bus value
//   ALU_OUT, Ovf      registered result and overflow of the last completed op
//   Busy, Done        multi-cycle in progress; 1-cycle completion pulse
//   N, Z, P           condition codes (one-hot)
module alu_exec_unit #(
  parameter int         WIDTH        = 16,
  parameter logic [2:0] CC_RESET_VAL = 3'b010
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       ALUK,
  input  logic [WIDTH-1:0] SR1,
  input  logic [WIDTH-1:0] SR2,
  input  logic             LD_CC,
  input  logic [WIDTH-1:0] BUS,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done,
  output logic             N,
  output logic             Z,
  output logic             P
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;

  // Single-cycle result. Operands are consumed at the accept edge, so
  // later operand changes cannot reach an op that is already in flight.
  logic [WIDTH-1:0] add_res, sc_res;
  logic             sc_ovf;

  assign add_res = SR1 + SR2;

  always_comb begin
    sc_res = SR1;
    sc_ovf = 1'b0;
    case (ALUK)
      OP_ADD: begin
        sc_res = add_res;
        sc_ovf = (SR1[WIDTH-1] == SR2[WIDTH-1]) && (add_res[WIDTH-1] != SR1[WIDTH-1]);
      end
      OP_AND:  sc_res = SR1 & SR2;
      OP_NOT:  sc_res = ~SR1;
      default: sc_res = SR1;
    endcase
  end

  logic accept;
  assign accept = Start && !Busy;

`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam int         CW     = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc, mcand, acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               is_mul, last;

  assign is_mul  = (ALUK == OP_MUL);
  // The last iteration writes its sum straight to ALU_OUT, so the result
  // lands WIDTH edges after the accept edge.
  assign last    = (cnt == CW'(WIDTH - 1));
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start && is_mul) state_nxt = S_MUL;
      S_MUL:   if (last)            state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == S_MUL);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ALU_OUT <= '0;
      Ovf     <= 1'b0;
      Done    <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      Done <= 1'b0;
      if (accept && !is_mul) begin
        ALU_OUT <= sc_res;
        Ovf     <= sc_ovf;
        Done    <= 1'b1;
      end
      if (accept && is_mul) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, SR1};
        mplier <= SR2;
        cnt    <= '0;
      end
      if (state == S_MUL) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) begin
          ALU_OUT <= acc_sum[WIDTH-1:0];
          Ovf     <= |acc_sum[2*WIDTH-1:WIDTH];
          Done    <= 1'b1;
        end
      end
    end
  end
`else
  assign Busy = 1'b0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ALU_OUT <= '0;
      Ovf     <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        ALU_OUT <= sc_res;
        Ovf     <= sc_ovf;
        Done    <= 1'b1;
      end
    end
  end
`endif

  // The condition codes follow BUS only and do not depend on the ALU result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {N, Z, P} <= CC_RESET_VAL;
    end else if (LD_CC) begin
      N <= BUS[WIDTH-1];
      Z <= (BUS == '0);
      P <= !BUS[WIDTH-1] && (BUS != '0);
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset, Start, LD_CC;
  logic [2:0]   ALUK;
  logic [W-1:0] SR1, SR2, BUS;
  logic [W-1:0] ALU_OUT;
  logic         Ovf, Busy, Done, N, Z, P;

  int n_vec = 0;
  int n_err = 0;
  logic [W:0] exp_q[$];   // {ovf, result}

  always #5 Clk = ~Clk;

  alu_exec_unit #(.WIDTH(W), .CC_RESET_VAL(3'b010)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALUK(ALUK), .SR1(SR1), .SR2(SR2),
    .LD_CC(LD_CC), .BUS(BUS), .ALU_OUT(ALU_OUT), .Ovf(Ovf), .Busy(Busy),
    .Done(Done), .N(N), .Z(Z), .P(P)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && Done === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got result 0x%0h with no op outstanding", ALU_OUT);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({Ovf, ALU_OUT} !== e) begin
          n_err++;
          $display("FAIL result: got ovf=%0b out=0x%0h expected ovf=%0b out=0x%0h",
                   Ovf, ALU_OUT, e[W], e[W-1:0]);
        end
      end
    end
  end

  // Drive one Start cycle; optionally queue the expected completion.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] er, input logic eo);
    Start = 1'b1; ALUK = op; SR1 = a; SR2 = b;
    if (push) exp_q.push_back({eo, er});
    @(posedge Clk); #1;
    Start = 1'b0; ALUK = 3'b111; SR1 = 16'hDEAD; SR2 = 16'hBEEF;
  endtask

  // Count Busy cycles (bounded), optionally poking an ADD mid-operation.
  task automatic busy_count(input int poke_at, output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!Busy) break;
      cyc++;
      if (i == poke_at) begin Start = 1'b1; ALUK = 3'b000; SR1 = 16'h0001; SR2 = 16'h0001; end
      @(posedge Clk); #1;
      Start = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin @(posedge Clk); #1; k++; end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  int bc;

  initial begin
    Reset = 1'b1; Start = 1'b0; LD_CC = 1'b0; ALUK = 3'b000;
    SR1 = '0; SR2 = '0; BUS = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_out",  {Ovf, ALU_OUT}, 0);
    chk("rst_ctl",  {Busy, Done}, 0);
    chk("rst_nzp",  {N, Z, P}, 3'b010);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // 1: ADD signed overflow, one-cycle latency
    issue(3'b000, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b1);
    chk("add_done_t1", Done, 1);
    chk("add_busy", Busy, 0);
    chk("add_out", ALU_OUT, 16'h8000);
    @(posedge Clk); #1;
    chk("add_done_clr", Done, 0);

    // 2: back-to-back single-cycle ops
    issue(3'b001, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 1'b0);
    issue(3'b010, 16'h00FF, 16'h5555, 1'b1, 16'hFF00, 1'b0);
    issue(3'b011, 16'h1234, 16'hFFFF, 1'b1, 16'h1234, 1'b0);
    chk("b2b_done3", Done, 1);
    @(posedge Clk); #1;
    drain();

    // 3: MUL 3*5 with an ignored Start mid-op
`ifdef ALU_MUL_EN
    issue(3'b100, 16'h0003, 16'h0005, 1'b1, 16'h000F, 1'b0);
    chk("mul_busy_t", Busy, 1);
    busy_count(4, bc);
    chk("mul_busy_cycles", bc, 16);
`else
    issue(3'b100, 16'h0003, 16'h0005, 1'b1, 16'h0003, 1'b0);
    busy_count(-1, bc);
    chk("mul_busy_cycles", bc, 0);
`endif
    chk("mul_done", Done, 1);
    // earliest re-accept right after Busy drops
    issue(3'b000, 16'h0002, 16'hFFFF, 1'b1, 16'h0001, 1'b0);
    chk("reaccept_done", Done, 1);
    drain();

    // 4: MUL overflow into high half
`ifdef ALU_MUL_EN
    issue(3'b100, 16'h0100, 16'h0100, 1'b1, 16'h0000, 1'b1);
    busy_count(-1, bc);
    chk("mul2_busy_cycles", bc, 16);
`else
    issue(3'b100, 16'h0100, 16'h0100, 1'b1, 16'h0100, 1'b0);
    chk("mul2_busy", Busy, 0);
    chk("mul2_out", ALU_OUT, 16'h0100);
`endif
    drain();

    // 5: condition codes
    LD_CC = 1'b1; BUS = 16'h8000; @(posedge Clk); #1;
    chk("nzp_neg", {N, Z, P}, 3'b100);
    BUS = 16'h0000; @(posedge Clk); #1;
    chk("nzp_zero", {N, Z, P}, 3'b010);
    BUS = 16'h0001; @(posedge Clk); #1;
    chk("nzp_pos", {N, Z, P}, 3'b001);
    LD_CC = 1'b0; BUS = 16'h8000; @(posedge Clk); #1;
    chk("nzp_hold", {N, Z, P}, 3'b001);
    // LD_CC together with a completion: NZP follows BUS, not the result
    LD_CC = 1'b1; BUS = 16'h0000;
    issue(3'b000, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b1);
    LD_CC = 1'b0;
    chk("nzp_vs_alu", {N, Z, P}, 3'b010);
    drain();

    // 6: reset during MUL, with a Start on the reset edge
    LD_CC = 1'b1; BUS = 16'h8000;
`ifdef ALU_MUL_EN
    issue(3'b100, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
`else
    issue(3'b100, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0);
`endif
    LD_CC = 1'b0;
    repeat (4) begin @(posedge Clk); #1; end
    Reset = 1'b1; Start = 1'b1; ALUK = 3'b000; SR1 = 16'h0004; SR2 = 16'h0004;
    @(posedge Clk); #1;
    Reset = 1'b0; Start = 1'b0;
    chk("rstmul_out", {Ovf, ALU_OUT}, 0);
    chk("rstmul_busy", Busy, 0);
    chk("rstmul_done", Done, 0);
    chk("rstmul_nzp", {N, Z, P}, 3'b010);
    repeat (20) begin @(posedge Clk); #1; end
    issue(3'b000, 16'h0002, 16'h0003, 1'b1, 16'h0005, 1'b0);
    chk("post_rst_done", Done, 1);
    chk("post_rst_out", ALU_OUT, 16'h0005);
    drain();
    repeat (3) begin @(posedge Clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
